fetch_unit: RTL and testbench

- Instruction Fetch (IF) stage of the 5-stage RV32I pipeline.
- Owns the PC and issues word requests on a request/grant/response instruction-memory port.
- Buffers returned instructions in a small in-order queue and presents one instruction plus its PC per cycle to the decode stage.
- Consumes the decode stage's stall, flush and branch-redirect outputs: it is the producer end of the IF→ID interface.

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// IF-stage bundle: decode-side controls, instruction-memory port and IF->ID outputs.
// FETCH_MISALIGN_TRAP_EN adds IF_misaligned_o.
interface fetch_unit_if;
    logic        stall_i;
    logic        flush_i;
    logic        branch_en_i;
    logic [31:0] branch_addr_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] IF_Instruction_o;
    logic [31:0] IF_PC_o;
    logic        IF_valid_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        IF_misaligned_o;
`endif

    modport master (
        input  stall_i, flush_i, branch_en_i, branch_addr_i,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o,
        output IF_Instruction_o, IF_PC_o, IF_valid_o
`ifdef FETCH_MISALIGN_TRAP_EN
        , output IF_misaligned_o
`endif
    );

    modport slave (
        output stall_i, flush_i, branch_en_i, branch_addr_i,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o,
        input  IF_Instruction_o, IF_PC_o, IF_valid_o
`ifdef FETCH_MISALIGN_TRAP_EN
        , input IF_misaligned_o
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, request/grant/response imem port, in-order queue, IF->ID register.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_unit_if.master  fetch
);
    localparam int          CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam int          PW      = $clog2(QUEUE_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [31:0]   r_respPc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [31:0]   r_qInstr [QUEUE_DEPTH];
    logic [31:0]   r_qPc    [QUEUE_DEPTH];
    logic [31:0]   r_ifInstr;
    logic [31:0]   r_ifPc;
    logic          r_ifValid;

    logic [CW:0]   w_inFlight;
    logic          w_req;
    logic          w_grant;
    logic          w_rspAccept;
    logic [CW-1:0] w_outNext;
    logic          w_deliver;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic          w_trapBlock;
    logic [31:0]   w_branchTarget;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_trap;
    logic w_misBranch;

    assign w_misBranch = fetch.branch_en_i & (fetch.branch_addr_i[1:0] != 2'b00);
    assign w_trapBlock = r_trap;
    assign fetch.IF_misaligned_o = r_trap;

    // Sticky until the next redirect; in-flight responses are already counted as discards.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_trap <= 1'b0;
        end else if (fetch.branch_en_i) begin
            r_trap <= w_misBranch;
        end
    end
`else
    assign w_trapBlock = 1'b0;
`endif

    assign w_branchTarget = fetch.branch_addr_i & ~32'h3;
    assign w_inFlight     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req          = rst_i & ~fetch.branch_en_i & ~w_trapBlock & (w_inFlight < DEPTH_W);
    assign w_grant        = w_req & fetch.imem_gnt_i;
    assign w_rspAccept    = fetch.imem_rvalid_i & (r_discard == '0) & ~fetch.branch_en_i;
    assign w_outNext      = r_outstanding + CW'(w_grant) - CW'(fetch.imem_rvalid_i);

    // A response arriving on an empty queue goes straight to the output (also squashed by flush).
    assign w_deliver = ~fetch.stall_i & ~fetch.branch_en_i & ~w_trapBlock;
    assign w_pop     = w_deliver & (r_count != '0);
    assign w_bypass  = w_deliver & (r_count == '0) & w_rspAccept;
    assign w_push    = w_rspAccept & ~w_bypass;

    assign fetch.imem_req_o       = w_req;
    assign fetch.imem_addr_o      = r_pc;
    assign fetch.IF_Instruction_o = r_ifInstr;
    assign fetch.IF_PC_o          = r_ifPc;
    assign fetch.IF_valid_o       = r_ifValid;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc          <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_outstanding <= '0;
            r_count       <= '0;
            r_discard     <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (fetch.branch_en_i) begin
                r_pc      <= w_branchTarget;
                r_respPc  <= w_branchTarget;
                r_count   <= '0;
                r_wrPtr   <= '0;
                r_rdPtr   <= '0;
                r_discard <= w_outNext;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rspAccept) begin
                    r_respPc <= r_respPc + 32'd4;
                end
                if (fetch.imem_rvalid_i && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_qInstr[r_wrPtr] <= fetch.imem_rdata_i;
            r_qPc[r_wrPtr]    <= r_respPc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ifInstr <= NOP;
            r_ifPc    <= 32'h0;
            r_ifValid <= 1'b0;
        end else if (fetch.branch_en_i) begin
            r_ifInstr <= NOP;
            r_ifValid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misBranch) begin
                r_ifPc <= fetch.branch_addr_i;
            end
`endif
        end else if (w_deliver) begin
            if (fetch.flush_i) begin
                r_ifInstr <= NOP;
                r_ifValid <= 1'b0;
            end else if (r_count != '0) begin
                r_ifInstr <= r_qInstr[r_rdPtr];
                r_ifPc    <= r_qPc[r_rdPtr];
                r_ifValid <= 1'b1;
            end else if (w_rspAccept) begin
                r_ifInstr <= fetch.imem_rdata_i;
                r_ifPc    <= r_respPc;
                r_ifValid <= 1'b1;
            end else begin
                r_ifInstr <= NOP;
                r_ifValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, program-order delivery model, directed corner cases
// followed by randomized grant/latency/stall/redirect traffic.
module tb_fetch_unit;
    localparam int          QD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(QD)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .fetch (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory model: granted addresses in order with the cycle they were granted in.
    logic [31:0] pendAddr[$];
    int          pendCyc[$];
    int          cycleNo    = 0;
    int          gntMode    = 1;
    int          rspMode    = 1;
    int          deliveries = 0;

    // Program-order model: next request address and next PC expected at the decode side.
    logic [31:0] expReqAddr = 32'h0;
    logic [31:0] expNext    = 32'h0;
    logic [31:0] prevInstr;
    logic [31:0] prevPc;
    logic        prevValid;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic br, input logic [31:0] ba);
        logic rsp;
        logic grant;
        @(negedge clk);
        bus.stall_i       = st;
        bus.flush_i       = fl;
        bus.branch_en_i   = br;
        bus.branch_addr_i = ba;
        rsp = (pendAddr.size() > 0) && (pendCyc[0] < cycleNo) &&
              ((rspMode == 1) || ((rspMode == 2) && ($urandom_range(0, 99) < 60)));
        bus.imem_rvalid_i = rsp;
        bus.imem_rdata_i  = rsp ? instrOf(pendAddr[0]) : $urandom;
        bus.imem_gnt_i    = (gntMode == 2) ? ($urandom_range(0, 99) < 70) : (gntMode == 1);
        #1;
        if (bus.imem_req_o) checkOutput("reqAddr", bus.imem_addr_o, expReqAddr);
        if (br) checkOutput("noReqOnRedirect", 32'(bus.imem_req_o), 32'd0);
        grant = bus.imem_req_o & bus.imem_gnt_i;
        @(posedge clk);
        #1;
        if (rsp) begin
            void'(pendAddr.pop_front());
            void'(pendCyc.pop_front());
        end
        if (grant) begin
            pendAddr.push_back(expReqAddr);
            pendCyc.push_back(cycleNo);
            expReqAddr = expReqAddr + 32'd4;
        end
        cycleNo++;
        checkOutput("credit", 32'(pendAddr.size() <= QD), 32'd1);

        if (br) begin
            expReqAddr = ba & ~32'h3;
            expNext    = ba & ~32'h3;
            checkOutput("redirectValid", 32'(bus.IF_valid_o), 32'd0);
            checkOutput("redirectNop", bus.IF_Instruction_o, NOP);
        end else if (st) begin
            checkOutput("stallHoldInstr", bus.IF_Instruction_o, prevInstr);
            checkOutput("stallHoldPc", bus.IF_PC_o, prevPc);
            checkOutput("stallHoldValid", 32'(bus.IF_valid_o), 32'(prevValid));
        end else if (fl) begin
            checkOutput("flushValid", 32'(bus.IF_valid_o), 32'd0);
            checkOutput("flushNop", bus.IF_Instruction_o, NOP);
            expNext = expNext + 32'd4;
        end else if (bus.IF_valid_o) begin
            checkOutput("deliverPc", bus.IF_PC_o, expNext);
            checkOutput("deliverInstr", bus.IF_Instruction_o, instrOf(expNext));
            expNext = expNext + 32'd4;
            deliveries++;
        end
        prevInstr = bus.IF_Instruction_o;
        prevPc    = bus.IF_PC_o;
        prevValid = bus.IF_valid_o;
    endtask

    initial begin
        logic [31:0] heldAddr;
        rst_n             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.branch_en_i   = 1'b0;
        bus.branch_addr_i = 32'h0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        #12;
        checkOutput("resetReq", 32'(bus.imem_req_o), 32'd0);
        checkOutput("resetInstr", bus.IF_Instruction_o, NOP);
        checkOutput("resetPc", bus.IF_PC_o, 32'h0);
        checkOutput("resetValid", 32'(bus.IF_valid_o), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("resetMisaligned", 32'(bus.IF_misaligned_o), 32'd0);
`endif
        prevInstr = bus.IF_Instruction_o;
        prevPc    = bus.IF_PC_o;
        prevValid = bus.IF_valid_o;
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle memory: first instruction two cycles after its grant, then one per cycle.
        gntMode = 1;
        rspMode = 1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("latencyBubble", 32'(bus.IF_valid_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("firstValid", 32'(bus.IF_valid_o), 32'd1);
        checkOutput("firstPc", bus.IF_PC_o, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("throughput", 32'(bus.IF_valid_o), 32'd1);
        end

        // Grant withheld: address and pc frozen, output drains to a bubble.
        gntMode  = 0;
        heldAddr = expReqAddr;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("gntHoldReq", 32'(bus.imem_req_o), 32'd1);
            checkOutput("gntHoldAddr", bus.imem_addr_o, heldAddr);
        end
        checkOutput("gntHoldDrained", 32'(bus.IF_valid_o), 32'd0);

        // Two requests outstanding, then redirect to 0x100 with a response landing in the same cycle.
        gntMode = 1;
        rspMode = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("twoOutstanding", 32'(pendAddr.size()), 32'd2);
        rspMode = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect under stall, let the queue fill, then flush the head (0x10); 0x14 must follow.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("afterFlushValid", 32'(bus.IF_valid_o), 32'd1);
        checkOutput("afterFlushPc", bus.IF_PC_o, 32'h14);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Address wrap across 2^32.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
        checkOutput("trapFlag", 32'(bus.IF_misaligned_o), 32'd1);
        checkOutput("trapPc", bus.IF_PC_o, 32'h102);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("trapNoReq", 32'(bus.imem_req_o), 32'd0);
            checkOutput("trapHoldPc", bus.IF_PC_o, 32'h102);
            checkOutput("trapHoldValid", 32'(bus.IF_valid_o), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
        checkOutput("trapCleared", 32'(bus.IF_misaligned_o), 32'd0);
`else
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
`endif
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Random grant, latency, stall and aligned redirects.
        gntMode = 2;
        rspMode = 2;
        for (int i = 0; i < 1500; i++) begin
            logic        st;
            logic        br;
            logic [31:0] ba;
            st = ($urandom_range(0, 99) < 20);
            br = ($urandom_range(0, 99) < 3);
            ba = (i % 7 == 0) ? 32'hFFFF_FFF0 : {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            applyStimulus(st, 1'b0, br, ba);
        end
        checkOutput("randomProgress", 32'(deliveries > 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
